// File: rtl/cla_sub_pipe_pkg.sv
// Purpose: shared widths, pipeline stage record and overflow helper for the CLA subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cla_pkg;

    localparam int SLICE_W = 4;
    localparam int N_SLICE = 4;
    localparam int W       = SLICE_W * N_SLICE;

    // One pipeline stage. The borrow (inverted carry) is stored rather than the
    // carry so that an all-zero reset image already reads as bout=0.
    typedef struct packed {
        logic         vld;    // stage holds a live operation
        logic [W-1:0] d;      // result bits computed so far, upper bits zero
        logic         bw;     // borrow out of the last computed slice (= ~carry)
        logic [W-1:0] a;      // minuend; bits above the computed slices still pending
        logic [W-1:0] b;      // subtrahend; bits above the computed slices still pending
        logic         a_sgn;  // a[W-1], carried along for overflow
        logic         b_sgn;  // b[W-1], carried along for overflow
    } stage_t;

    // Signed overflow of a - b: operands of opposite sign and the result sign
    // disagrees with the minuend.
    function automatic logic sub_ovf(input logic a_sgn, input logic b_sgn, input logic d_sgn);
        return (a_sgn != b_sgn) && (d_sgn != a_sgn);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purpose: combinational 4-bit carry-lookahead adder slice (sum = a + b + cin).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing stage register decides when results are captured.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    // Generate/propagate terms and fully flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[SLICE_W-1:0];
        cout = c[SLICE_W];
    end

endmodule

// File: rtl/cla_sub_pipe.sv
// Purpose: 16-bit pipelined a - b - bin, one 4-bit CLA slice per stage, borrow registered between stages.
// Latency: 4 cycles from accept to out_valid; sustains one operation per cycle.
// Backpressure: per-stage valid/ready, bubbles collapse; in_ready follows out_ready combinationally when full.
module cla_sub_pipe
    import cla_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    stage_t             st     [N_SLICE];
    logic [N_SLICE-1:0] vld;
    logic [N_SLICE-1:0] rdy;

    logic [SLICE_W-1:0] sl_a   [N_SLICE];
    logic [SLICE_W-1:0] sl_b   [N_SLICE];
    logic [SLICE_W-1:0] sl_sum [N_SLICE];
    logic [N_SLICE-1:0] sl_cin;
    logic [N_SLICE-1:0] sl_cout;

    logic               unused_ops;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLICE; gi++) begin : g_stage
            assign vld[gi] = st[gi].vld;

            // A stage can take new data if it or any stage downstream has a hole,
            // or the sink is draining; written in closed form to keep the chain acyclic.
            assign rdy[gi] = out_ready | ~(&vld[N_SLICE-1:gi]);

            // Subtraction as addition: b is inverted here, borrow-in becomes carry-in.
            if (gi == 0) begin : g_first
                assign sl_a[gi]   = a[SLICE_W-1:0];
                assign sl_b[gi]   = ~b[SLICE_W-1:0];
                assign sl_cin[gi] = ~bin;
            end else begin : g_rest
                assign sl_a[gi]   = st[gi-1].a[gi*SLICE_W +: SLICE_W];
                assign sl_b[gi]   = ~st[gi-1].b[gi*SLICE_W +: SLICE_W];
                assign sl_cin[gi] = ~st[gi-1].bw;
            end

            cla4_slice u_slice (
                .a    (sl_a[gi]),
                .b    (sl_b[gi]),
                .cin  (sl_cin[gi]),
                .sum  (sl_sum[gi]),
                .cout (sl_cout[gi])
            );
        end
    endgenerate

    assign in_ready = rdy[0] & ~rst;

    // Advance each ready stage from its upstream neighbour; data only moves with a live op.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SLICE; i++) begin
                st[i] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                st[0].vld <= in_valid;
                if (in_valid) begin
                    st[0].d     <= W'(sl_sum[0]);
                    st[0].bw    <= ~sl_cout[0];
                    st[0].a     <= a;
                    st[0].b     <= b;
                    st[0].a_sgn <= a[W-1];
                    st[0].b_sgn <= b[W-1];
                end
            end
            for (int i = 1; i < N_SLICE; i++) begin
                if (rdy[i]) begin
                    st[i].vld <= st[i-1].vld;
                    if (st[i-1].vld) begin
                        st[i].d     <= st[i-1].d | (W'(sl_sum[i]) << (i * SLICE_W));
                        st[i].bw    <= ~sl_cout[i];
                        st[i].a     <= st[i-1].a;
                        st[i].b     <= st[i-1].b;
                        st[i].a_sgn <= st[i-1].a_sgn;
                        st[i].b_sgn <= st[i-1].b_sgn;
                    end
                end
            end
        end
    end

    // Output view of the last stage; held by the stage itself while stalled.
    always_comb begin
        out_valid = st[N_SLICE-1].vld;
        diff      = st[N_SLICE-1].d;
        bout      = st[N_SLICE-1].bw;
        ovf       = sub_ovf(st[N_SLICE-1].a_sgn, st[N_SLICE-1].b_sgn, st[N_SLICE-1].d[W-1]);
    end

    // Operand bits already consumed by earlier slices are carried for simplicity
    // and trimmed by synthesis; folded here so they are not read as dangling.
    always_comb begin
        unused_ops = 1'b0;
        for (int i = 0; i < N_SLICE; i++) begin
            unused_ops = unused_ops ^ (^{st[i].a, st[i].b});
        end
    end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Purpose: directed self-checking bench for the pipelined CLA subtractor.
// Latency: checks 4-cycle accept-to-output timing and 1/cycle streaming.
// Backpressure: exercises a 6-cycle sink stall and a mid-flight reset.
module tb_cla_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_sub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    // Reference: unsigned borrow from a 17-bit subtract, overflow from a signed range test.
    function automatic logic [17:0] ref_sub(input logic [15:0] ra, input logic [15:0] rb, input logic rbin);
        logic [16:0] r;
        int          s;
        logic        o;
        r = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
        s = int'($signed(ra)) - int'($signed(rb)) - (rbin ? 1 : 0);
        o = (s > 32767) || (s < -32768);
        return {o, r[16], r[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || diff !== 16'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h bo=%b ov=%b exp v=0 d=0000 bo=0 ov=0", out_valid, diff, bout, ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_high got=%b exp=1", in_ready); end
    endtask

    task automatic test_single(input string nm, input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                               input logic [15:0] ed, input logic eb, input logic eo);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_; bin = tbin;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_accept in_ready got=%b exp=1", nm, in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            checks++;
            if (n == 4) begin
                if (out_valid !== 1'b1 || diff !== ed || bout !== eb || ovf !== eo) begin
                    failures++;
                    $display("FAIL %s_result got v=%b d=%h bo=%b ov=%b exp v=1 d=%h bo=%b ov=%b",
                             nm, out_valid, diff, bout, ovf, ed, eb, eo);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_latency cycle=%0d out_valid got=%b exp=0", nm, n, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va   [10] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0000, 16'hABCD,
                                   16'h1000, 16'h8000, 16'h00FF, 16'h5555, 16'hFFFF};
        logic [15:0] vb   [10] = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h1234,
                                   16'h0FFF, 16'h7FFF, 16'h0100, 16'hAAAA, 16'h0000};
        logic        vbin [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [17:0] exp_r [10];
        int   tx = 0;
        int   rx = 0;
        int   cyc = 0;
        logic held = 1'b0;
        logic saw_full = 1'b0;
        logic exp_ir;

        for (int i = 0; i < 10; i++) exp_r[i] = ref_sub(va[i], vb[i], vbin[i]);

        while (rx < 10 && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc < 12);
            if (tx < 10) begin
                in_valid = 1'b1; a = va[tx]; b = vb[tx]; bin = vbin[tx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || diff !== exp_r[rx][15:0] || bout !== exp_r[rx][16] || ovf !== exp_r[rx][17]) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got v=%b d=%h bo=%b ov=%b exp v=1 d=%h bo=%b ov=%b",
                             cyc, out_valid, diff, bout, ovf, exp_r[rx][15:0], exp_r[rx][16], exp_r[rx][17]);
                end
            end
            exp_ir = !((tx - rx) == 4 && !out_ready);
            checks++;
            if (in_ready !== exp_ir) begin
                failures++;
                $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ir);
            end
            if (in_ready === 1'b0) saw_full = 1'b1;
            held = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                checks++;
                if (diff !== exp_r[rx][15:0] || bout !== exp_r[rx][16] || ovf !== exp_r[rx][17]) begin
                    failures++;
                    $display("FAIL b2b_result idx=%0d got d=%h bo=%b ov=%b exp d=%h bo=%b ov=%b",
                             rx, diff, bout, ovf, exp_r[rx][15:0], exp_r[rx][16], exp_r[rx][17]);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rx != 10) begin failures++; $display("FAIL b2b_timeout received=%0d exp=10", rx); end
        checks++;
        if (!saw_full) begin failures++; $display("FAIL b2b_full in_ready_dropped got=0 exp=1"); end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_extra cyc=%0d out_valid got=%b exp=0", n, out_valid); end
        end
    endtask

    task automatic test_reset_flight();
        logic [15:0] fa [3] = '{16'hFFFF, 16'h0000, 16'h8000};
        logic [15:0] fb [3] = '{16'h0001, 16'h0001, 16'h0001};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = fa[i]; b = fb[i]; bin = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL flight_rst_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || diff !== 16'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL flight_rst_outputs got v=%b d=%h bo=%b ov=%b exp v=0 d=0000 bo=0 ov=0", out_valid, diff, bout, ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL flight_rst_in_ready_after got=%b exp=1", in_ready); end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL flight_stale cyc=%0d out_valid got=%b exp=0", n, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single("sub_basic",  16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        test_single("sub_wrap",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        test_single("sub_ovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        test_single("sub_eq_bin", 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        test_back_to_back();
        test_reset_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
